// File: rtl/acc_sequencer_if.sv
// Command and accumulator-control signals between the scheduler/array side
// and acc_sequencer.
interface acc_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [3:0]       cmd_addr;
  logic             col_valid;
  logic             acc_reset;
  logic             store_output;
  logic [3:0]       op_buffer_address;
  logic             busy;
  logic             done;
  logic             beat_err;

  modport master (
    output cmd_valid, cmd_len, cmd_addr, col_valid,
    input  cmd_ready, acc_reset, store_output, op_buffer_address, busy, done, beat_err
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_addr, col_valid,
    output cmd_ready, acc_reset, store_output, op_buffer_address, busy, done, beat_err
  );
endinterface

// File: rtl/acc_sequencer.sv
// Control FSM for the Accumulator stage: clears it, counts column-sum beats,
// waits out the adder pipeline, then issues a single store to the output buffer.
module acc_sequencer #(
  parameter int DRAIN_CYCLES = 5,
  parameter int LEN_W        = 8
) (
  input  logic           clk,
  input  logic           rst,
  acc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    STORE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] remaining;
  logic [3:0]       drain_cnt;
  logic [3:0]       addr_q;
  logic             err_q;
  logic             accept;

  assign accept = bus.cmd_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The drain counter is loaded on the transition into DRAIN, so its first
  // DRAIN cycle already holds the full DRAIN_CYCLES count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      drain_cnt <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        remaining <= bus.cmd_len;
        addr_q    <= bus.cmd_addr;
      end else if ((state == ACCUM) && bus.col_valid && (remaining != '0)) begin
        remaining <= remaining - LEN_W'(1);
      end

      if ((state_nxt == DRAIN) && (state != DRAIN)) begin
        drain_cnt <= 4'(DRAIN_CYCLES);
      end else if ((state == DRAIN) && (drain_cnt != 4'd0)) begin
        drain_cnt <= drain_cnt - 4'd1;
      end

      if (accept) begin
        err_q <= 1'b0;
      end else if (bus.col_valid && (state != ACCUM)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.cmd_ready    = 1'b0;
    bus.acc_reset    = 1'b0;
    bus.store_output = 1'b0;
    bus.done         = 1'b0;
    bus.busy         = 1'b1;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        bus.acc_reset = 1'b1;
        state_nxt     = (remaining != '0) ? ACCUM : DRAIN;
      end
      ACCUM: begin
        if (bus.col_valid && (remaining <= LEN_W'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt <= 4'd1) begin
          state_nxt = STORE;
        end
      end
      STORE: begin
        bus.store_output = 1'b1;
        bus.done         = 1'b1;
        state_nxt        = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.op_buffer_address = addr_q;
  assign bus.beat_err          = err_q;

endmodule
